// File: rtl/agg_pkg.sv
// agg_pkg: shared definitions for the aggregation stage.
//   - activation mode encodings (value 3 is handled like RAW)
//   - two-state FSM type
//   - accumulator width helper: N bits of input plus log2(LEN) growth bits
package agg_pkg;

  localparam logic [1:0] ACT_RAW  = 2'd0;
  localparam logic [1:0] ACT_RELU = 2'd1;
  localparam logic [1:0] ACT_NEG  = 2'd2;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Summing LEN N-bit signed values needs at most $clog2(LEN) extra bits.
  function automatic int acc_width(input int n, input int len);
    return n + $clog2(len);
  endfunction

endpackage

// File: rtl/agg_act_clamp.sv
// agg_act_clamp: per-channel activation and clamp (combinational).
//   sum  : ACC_W-bit signed accumulated value
//   mode : activation select (RAW / RELU / NEG, 3 behaves as RAW)
//   res  : N-bit signed result
//   sat  : result was clamped to the N-bit range
module agg_act_clamp
  import agg_pkg::*;
#(
  parameter int N     = 12,
  parameter int ACC_W = 15
) (
  input  logic [ACC_W-1:0] sum,
  input  logic [1:0]       mode,
  output logic [N-1:0]     res,
  output logic             sat
);

  // N-bit signed limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXN = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

  logic signed [ACC_W-1:0] s;
  logic                    over, under;
  logic [N-1:0]            clamped;

  assign s     = sum;
  assign over  = (s > MAXV);
  assign under = (s < MINV);

  always_comb begin
    if (over)       clamped = MAXN;
    else if (under) clamped = MINN;
    else            clamped = sum[N-1:0];
  end

  always_comb begin
    res = clamped;
    sat = over | under;
    case (mode)
      ACT_RELU: begin
        // Negative sums go to zero; that is not counted as saturation.
        if (s[ACC_W-1]) begin
          res = '0;
          sat = 1'b0;
        end else begin
          res = clamped;
          sat = over;
        end
      end
      ACT_NEG: res = ~clamped;
      default: ;
    endcase
  end

endmodule

// File: rtl/agg_acc.sv
// agg_acc: multi-channel accumulate-and-activate stage.
// Accepts CH signed N-bit partial sums per beat, accumulates LEN beats per
// channel, then emits one activated/clamped CH-wide result word.
//   clk, rst_n          : clock, async active-low reset
//   clr                 : synchronous abort (drops partial sums and result)
//   act_mode            : activation select, sampled with the final beat
//   in_valid/in_ready   : input handshake, in_data channel c at [c*N +: N]
//   out_valid/out_ready : output handshake
//   out_data, out_sat   : registered result word and per-channel clamp flags
module agg_acc
  import agg_pkg::*;
#(
  parameter int N     = 12,
  parameter int CH    = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = acc_width(N, LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [1:0]      act_mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*N-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*N-1:0] out_data,
  output logic [CH-1:0]   out_sat
);

  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t state_q, state_d;
  logic   run_q;  // low during reset so in_ready reads 0 while rst_n is low

  logic [CH-1:0][N-1:0]     in_ch;
  logic [CH-1:0][ACC_W-1:0] acc_q, sum_nx;
  logic [CH-1:0][N-1:0]     res, data_q;
  logic [CH-1:0]            sat, sat_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     accept, last_beat;

  assign in_ch     = in_data;
  assign in_ready  = run_q & (state_q == S_ACC);
  assign accept    = in_valid & in_ready;
  assign last_beat = accept & (cnt_q == LAST);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = data_q;
  assign out_sat   = sat_q;

  // Per-channel sum including the beat on the bus and its activation.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign sum_nx[c] = acc_q[c] + {{(ACC_W-N){in_ch[c][N-1]}}, in_ch[c]};

    agg_act_clamp #(.N(N), .ACC_W(ACC_W)) u_clamp (
      .sum  (sum_nx[c]),
      .mode (act_mode),
      .res  (res[c]),
      .sat  (sat[c])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_ACC;
    end else begin
      case (state_q)
        S_ACC:   if (last_beat) state_d = S_OUT;
        S_OUT:   if (out_ready) state_d = S_ACC;
        default: state_d = S_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // clr wins over a beat accepted in the same cycle; that beat is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      sat_q  <= '0;
    end else if (clr) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      sat_q  <= '0;
    end else if (last_beat) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= res;
      sat_q  <= sat;
    end else if (accept) begin
      acc_q  <= sum_nx;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_agg_acc.sv
module tb_agg_acc;

  localparam int N = 12, CH = 4, LEN = 8;

  logic            clk = 1'b0;
  logic            rst_n, clr, in_valid, out_ready;
  logic [1:0]      act_mode;
  logic            in_ready, out_valid;
  logic [CH*N-1:0] in_data, out_data;
  logic [CH-1:0]   out_sat;

  int n_chk = 0;
  int n_err = 0;

  agg_acc #(.N(N), .CH(CH), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .act_mode  (act_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [47:0] din;
    logic [47:0] exp_d;
    logic [3:0]  exp_s;
  } vec_t;

  vec_t vt[5];

  function automatic logic [47:0] pack(input int c0, input int c1, input int c2, input int c3);
    logic [11:0] a, b, c, d;
    a = c0[11:0]; b = c1[11:0]; c = c2[11:0]; d = c3[11:0];
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [47:0] d, input logic [1:0] m);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b1;
    in_data  = d;
    act_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_valid_low", 64'(out_valid), 64'd0);
  endtask

  logic [47:0] held_d;
  logic [3:0]  held_s;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    act_mode = 2'd0; in_data = pack(5, 5, 5, 5);

    vt[0].name = "raw100";  vt[0].mode = 2'd0; vt[0].din = pack(100, 100, 100, 100);
    vt[0].exp_d = pack(800, 800, 800, 800);     vt[0].exp_s = 4'b0000;
    vt[1].name = "raw_sat"; vt[1].mode = 2'd0; vt[1].din = pack(2047, -2048, 0, 1);
    vt[1].exp_d = pack(2047, -2048, 0, 8);      vt[1].exp_s = 4'b0011;
    vt[2].name = "neg_sat"; vt[2].mode = 2'd2; vt[2].din = pack(2047, -2048, 0, 1);
    vt[2].exp_d = pack(-2048, 2047, -1, -9);    vt[2].exp_s = 4'b0011;
    vt[3].name = "relu";    vt[3].mode = 2'd1; vt[3].din = pack(2047, -2048, -5, 5);
    vt[3].exp_d = pack(2047, 0, 0, 40);         vt[3].exp_s = 4'b0001;
    vt[4].name = "mode3";   vt[4].mode = 2'd3; vt[4].din = pack(-1, 255, 256, -257);
    vt[4].exp_d = pack(-8, 2040, 2047, -2048);  vt[4].exp_s = 4'b1100;

    // Reset with in_valid high: nothing moves, in_ready held low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    idle(5);
    chk("idle_no_output", 64'(out_valid), 64'd0);

    // Table vectors; non-final beats carry a different act_mode.
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < LEN; b++) begin
        send(vt[v].din, (b == LEN - 1) ? vt[v].mode : ~vt[v].mode);
        if (b == LEN - 2) chk({vt[v].name, "_early"}, 64'(out_valid), 64'd0);
      end
      chk({vt[v].name, "_valid"}, 64'(out_valid), 64'd1);
      chk({vt[v].name, "_data"}, 64'(out_data), 64'(vt[v].exp_d));
      chk({vt[v].name, "_sat"}, 64'(out_sat), 64'(vt[v].exp_s));
      chk({vt[v].name, "_in_ready"}, 64'(in_ready), 64'd0);
      consume();
    end

    // Gaps plus backpressure: beats 1..8 per channel sum to 36.
    for (int b = 0; b < LEN; b++) begin
      send(pack(b + 1, b + 1, b + 1, b + 1), 2'd0);
      idle(int'($urandom_range(0, 2)));
    end
    chk("bp_data", 64'(out_data), 64'(pack(36, 36, 36, 36)));
    held_d = out_data;
    held_s = out_sat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pack(1000, 1000, 1000, 1000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_stable", 64'({held_s, held_d}), 64'({out_sat, out_data}));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    for (int b = 0; b < LEN; b++) send(pack(10, 10, 10, 10), 2'd0);
    chk("bp_next_data", 64'(out_data), 64'(pack(80, 80, 80, 80)));
    chk("bp_next_sat", 64'(out_sat), 64'd0);
    consume();

    // Abort: 3 beats, then clr together with a beat, then a fresh 8 beats.
    for (int b = 0; b < 3; b++) send(pack(50, 50, 50, 50), 2'd0);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = pack(7, 7, 7, 7);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    for (int b = 0; b < LEN; b++) begin
      send(pack(1, 1, 1, 1), 2'd0);
      if (b == LEN - 2) chk("clr_early", 64'(out_valid), 64'd0);
    end
    chk("clr_valid", 64'(out_valid), 64'd1);
    chk("clr_data", 64'(out_data), 64'(pack(8, 8, 8, 8)));

    // clr while in OUT drops the result.
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_out_data", 64'(out_data), 64'd0);

    // Reset pulse in OUT: out_valid drops without waiting for a clock.
    for (int b = 0; b < LEN; b++) send(pack(3, 3, 3, 3), 2'd0);
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_data", 64'(out_data), 64'd0);
    chk("rst_async_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < LEN; b++) send(pack(-2, 2, 0, 4), 2'd0);
    chk("rst_after_data", 64'(out_data), 64'(pack(-16, 16, 0, 32)));
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/agg_acc.md
# agg_acc

Parametrised multi-channel aggregation stage between the PE array and the ALU/activation path of the neural-network accelerator. Accepts CH signed N-bit partial sums per beat over a valid/ready handshake, accumulates LEN beats per channel, then applies a selectable activation/clamp. Presents one CH-wide N-bit result word per LEN input beats on a valid/ready output. It generalises the single-channel 12-bit aggregation register: adds width/channel/depth parameters, accumulation, saturation and activation modes, and flow control.

## Interface
Parameters:
- N, 12, input and output element width (signed two's complement)
- CH, 4, number of parallel channels
- LEN, 8, beats accumulated per result (≥2)
- ACC_W, N+$clog2(LEN), internal accumulator width per channel

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous abort: clears accumulators, beat count and output register
- act_mode  input  2  0 RAW clamp, 1 RELU, 2 NEG (bitwise inverse of clamped value), 3 treated as RAW
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  CH*N  channel c at bits [c*N +: N]
- out_valid  output  1  result word valid
- out_ready  input  1  downstream accepts result
- out_data  output  CH*N  activated results, same packing as in_data
- out_sat  output  CH  per-channel flag: clamp was applied to this result

## Operation
- FSM with two states, ACC and OUT. Reset state is ACC.
- ACC: in_ready=1. On in_valid&&in_ready, add the sign-extended in_data[c] into acc[c] (ACC_W bits; no internal overflow by construction) and increment beat count cnt.
- On acceptance of beat cnt==LEN-1:
  - compute results from acc+in_data and act_mode sampled that cycle
  - load out_data/out_sat, clear acc and cnt, go to OUT
- OUT: in_ready=0, out_valid=1. out_data/out_sat are held stable until out_valid&&out_ready, then go to ACC.
- Per-channel result from the ACC_W-bit sum s:
  - RAW: clamp s to [-2^(N-1), 2^(N-1)-1]; out_sat=1 iff clamped
  - RELU: s<0 → 0 with out_sat=0; else clamp upper bound with out_sat as RAW
  - NEG: clamp as RAW, then bitwise invert; out_sat as RAW
- clr (any state): next cycle acc=0, cnt=0, out_valid=0, state ACC. clr takes priority over a beat accepted in the same cycle; that beat is dropped.
- Reset values: in_ready=0 while rst_n low, then 1; out_valid=0, out_data=0, out_sat=0, acc=0, cnt=0.

## Timing
- Output latency: out_valid rises on the clock edge that accepts beat LEN-1, i.e. one cycle after that beat is presented.
- Max throughput: one result per LEN+1 cycles when out_ready is held high (LEN accept cycles plus one OUT cycle).
- in_ready depends only on state, never combinationally on in_valid or out_ready. out_valid, out_data and out_sat are registered.
- Backpressure: out_ready low holds OUT indefinitely with stable data; no input is accepted meanwhile.
- in_valid gaps in ACC stall accumulation without loss; cnt does not advance.
- Reset asserted mid-accumulation or in OUT: all state clears asynchronously and the partial sum is discarded.
- act_mode changes are ignored except in the cycle the final beat is accepted.

## Structure
- Shared package agg_pkg holds:
  - act_mode encodings (ACT_RAW=2'd0, ACT_RELU=2'd1, ACT_NEG=2'd2)
  - FSM state typedef
  - a clog2-based ACC_W helper
- One natural sub-module: agg_act_clamp. Combinational, one per channel, generate-instantiated CH times. Inputs: ACC_W sum and mode. Outputs: N-bit result and sat flag.
- The top level holds the FSM, beat counter, accumulator array and output registers.

## Test plan
- Reset/idle: rst_n low with in_valid=1 → out_valid=0, out_data=0, in_ready=0; after release in_ready=1, no output produced without beats.
- RAW sum, N=12, LEN=8, CH=4: every channel receives 100 per beat → out_data all 800, out_sat=0, out_valid exactly one cycle after the 8th beat.
- Saturation: channel 0 gets 2047×8, channel 1 gets −2048×8, mode RAW → ch0=2047 and ch1=−2048, out_sat=4'b0011; mode NEG on ch0 → 12'h800.
- RELU: channel 2 sums to −40 and channel 3 to +40 → ch2=0 with sat=0, ch3=40.
- Backpressure/gaps: random in_valid gaps plus out_ready low for 5 cycles → out_data stable and in_ready=0 throughout; the next result is correct and no beat is lost or duplicated.
- Abort: clr asserted after beat 3 together with an in_valid beat, then 8 beats of 1 → result is 8 per channel. Separately, rst_n pulsed low in OUT → out_valid drops immediately.
